// File: rtl/gb_apu_pkg.sv
// Shared types and default widths for the APU volume-envelope logic.
package gb_apu_pkg;

  // Default volume width (VMAX = 15) and sweep-period width (0..7 ticks).
  localparam int VOL_W_DEF = 4;
  localparam int PER_W_DEF = 3;

  // Per-channel envelope sequencer state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } env_state_e;

endpackage : gb_apu_pkg

// File: rtl/gb_envelope_channel.sv
// One volume-envelope channel: edge-triggered restart, periodic +/-1 volume
// steps on the shared 64 Hz tick, saturating at 0 and VMAX.
module gb_envelope_channel
  import gb_apu_pkg::*;
#(
  parameter int VOL_W = VOL_W_DEF,
  parameter int PER_W = PER_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_i,
  input  logic             start_i,
  input  logic [VOL_W-1:0] init_vol_i,
  input  logic             inc_i,
  input  logic [PER_W-1:0] period_i,
  output logic [VOL_W-1:0] vol_o,
  output logic             active_o,
  output logic             dac_off_o
);

  localparam logic [VOL_W-1:0] VMAX = '1;

  env_state_e       state_q;
  logic [VOL_W-1:0] vol_q;
  logic [PER_W-1:0] cnt_q;
  logic [PER_W-1:0] per_q;
  logic             dir_q;
  logic             start_q;
  logic             dac_off_q;

  logic             trig;
  logic             expire;
  logic             at_bound;
  logic             next_at_bound;
  logic [VOL_W-1:0] vol_d;

  // Rising edge of start against last cycle's copy; a held level fires once.
  assign trig          = start_i & ~start_q;
  // Period counter runs out on this tick.
  assign expire        = tick_i && (state_q == RUN) && (cnt_q <= PER_W'(1));
  // Volume already pinned in the latched direction: expiry ends the sweep.
  assign at_bound      = dir_q ? (vol_q == VMAX) : (vol_q == '0);
  // The step about to be taken lands on the bound.
  assign next_at_bound = dir_q ? (vol_q == VMAX - VOL_W'(1)) : (vol_q == VOL_W'(1));
  assign vol_d         = dir_q ? vol_q + VOL_W'(1) : vol_q - VOL_W'(1);

  // Envelope FSM with its volume, counter and latched settings.
  // NOTE: every register here is assigned with <= so all of them update from
  // the same pre-edge values; a blocking '=' would let later lines see
  // half-updated state and break simulation/synthesis agreement.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      vol_q     <= '0;
      cnt_q     <= '0;
      per_q     <= '0;
      dir_q     <= 1'b0;
      start_q   <= 1'b0;
      dac_off_q <= 1'b1;
    end else begin
      start_q <= start_i;
      if (trig) begin
        // Trigger overrides any tick arriving in the same cycle.
        vol_q     <= init_vol_i;
        per_q     <= period_i;
        dir_q     <= inc_i;
        cnt_q     <= period_i;
        dac_off_q <= (init_vol_i == '0) && !inc_i;
        state_q   <= (period_i != '0) ? RUN : DONE;
      end else if (tick_i && state_q == RUN) begin
        if (!expire) begin
          cnt_q <= cnt_q - PER_W'(1);
        end else begin
          cnt_q <= per_q;
          if (at_bound) begin
            state_q <= DONE;
          end else begin
            vol_q <= vol_d;
            if (next_at_bound) begin
              state_q <= DONE;
            end
          end
        end
      end
    end
  end

  assign vol_o     = vol_q;
  assign active_o  = (state_q == RUN);
  assign dac_off_o = dac_off_q;

endmodule : gb_envelope_channel

// File: rtl/gb_envelope_bank.sv
// Bank of independent envelope channels (pulse 1, pulse 2, noise) sharing
// one 64 Hz envelope tick.
module gb_envelope_bank
  import gb_apu_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int VOL_W  = VOL_W_DEF,
  parameter int PER_W  = PER_W_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clk_vol_env,
  input  logic [NUM_CH-1:0]            start,
  input  logic [NUM_CH-1:0][VOL_W-1:0] initial_volume,
  input  logic [NUM_CH-1:0]            envelope_increasing,
  input  logic [NUM_CH-1:0][PER_W-1:0] num_envelope_sweeps,
  output logic [NUM_CH-1:0][VOL_W-1:0] target_vol,
  output logic [NUM_CH-1:0]            env_active,
  output logic [NUM_CH-1:0]            dac_off
);

  // One channel per slot; the tick fans out unchanged to all of them.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    gb_envelope_channel #(
      .VOL_W (VOL_W),
      .PER_W (PER_W)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .tick_i     (clk_vol_env),
      .start_i    (start[g]),
      .init_vol_i (initial_volume[g]),
      .inc_i      (envelope_increasing[g]),
      .period_i   (num_envelope_sweeps[g]),
      .vol_o      (target_vol[g]),
      .active_o   (env_active[g]),
      .dac_off_o  (dac_off[g])
    );
  end

endmodule : gb_envelope_bank

// File: tb/tb_gb_envelope_bank.sv
// Directed self-checking bench for gb_envelope_bank with hand-computed
// expected volumes. Inputs change on the falling edge, outputs are sampled
// on the falling edge after the rising edge that consumed them.
module tb_gb_envelope_bank;

  localparam int NUM_CH = 3;
  localparam int VOL_W  = 4;
  localparam int PER_W  = 3;

  logic                         clk = 1'b0;
  logic                         reset;
  logic                         clk_vol_env;
  logic [NUM_CH-1:0]            start;
  logic [NUM_CH-1:0][VOL_W-1:0] initial_volume;
  logic [NUM_CH-1:0]            envelope_increasing;
  logic [NUM_CH-1:0][PER_W-1:0] num_envelope_sweeps;
  logic [NUM_CH-1:0][VOL_W-1:0] target_vol;
  logic [NUM_CH-1:0]            env_active;
  logic [NUM_CH-1:0]            dac_off;

  int n_vec = 0;
  int n_err = 0;

  gb_envelope_bank #(
    .NUM_CH (NUM_CH),
    .VOL_W  (VOL_W),
    .PER_W  (PER_W)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .clk_vol_env         (clk_vol_env),
    .start               (start),
    .initial_volume      (initial_volume),
    .envelope_increasing (envelope_increasing),
    .num_envelope_sweeps (num_envelope_sweeps),
    .target_vol          (target_vol),
    .env_active          (env_active),
    .dac_off             (dac_off)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a falling edge; applies tick/start for one rising edge and
  // returns at the next falling edge with the tick pulse removed.
  task automatic step(input logic tk, input logic [NUM_CH-1:0] st);
    start       = st;
    clk_vol_env = tk;
    @(posedge clk);
    #1 clk_vol_env = 1'b0;
    @(negedge clk);
  endtask

  task automatic cfg(input int ch, input int iv, input logic inc, input int per);
    initial_volume[ch]      = VOL_W'(iv);
    envelope_increasing[ch] = inc;
    num_envelope_sweeps[ch] = PER_W'(per);
  endtask

  // Watchdog so the run can never hang.
  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset               = 1'b1;
    clk_vol_env         = 1'b0;
    start               = '0;
    initial_volume      = '0;
    envelope_increasing = '0;
    num_envelope_sweeps = '0;
    @(negedge clk);
    @(negedge clk);
    for (int c = 0; c < NUM_CH; c++) check($sformatf("rst_vol%0d", c), int'(target_vol[c]), 0);
    check("rst_active", int'(env_active), 0);
    check("rst_dac_off", int'(dac_off), 7);
    reset = 1'b0;
    @(negedge clk);

    // Ch0 ramps 0 -> 15 one step per tick, then holds; start stays high.
    cfg(0, 0, 1'b1, 1);
    step(1'b0, 3'b001);
    check("up_trig_vol", int'(target_vol[0]), 0);
    check("up_trig_active", int'(env_active[0]), 1);
    check("up_dac_off", int'(dac_off[0]), 0);
    for (int t = 1; t <= 20; t++) begin
      step(1'b1, 3'b001);
      check($sformatf("up_vol_t%0d", t), int'(target_vol[0]), (t < 15) ? t : 15);
      check($sformatf("up_act_t%0d", t), int'(env_active[0]), (t < 15) ? 1 : 0);
    end
    step(1'b0, 3'b000);

    // Trigger already at the bound: first expiry ends the sweep, no step.
    cfg(0, 15, 1'b1, 1);
    step(1'b0, 3'b001);
    check("bound_trig_act", int'(env_active[0]), 1);
    step(1'b1, 3'b001);
    check("bound_vol", int'(target_vol[0]), 15);
    check("bound_act", int'(env_active[0]), 0);
    step(1'b0, 3'b000);

    // Ch1 falls 15 -> 0 every 3rd tick; settings changed after the trigger.
    cfg(1, 15, 1'b0, 3);
    step(1'b0, 3'b010);
    check("dn_trig_vol", int'(target_vol[1]), 15);
    check("dn_trig_act", int'(env_active[1]), 1);
    cfg(1, 3, 1'b1, 1);
    for (int t = 1; t <= 45; t++) begin
      step(1'b1, 3'b010);
      check($sformatf("dn_vol_t%0d", t), int'(target_vol[1]), 15 - t / 3);
      check($sformatf("dn_act_t%0d", t), int'(env_active[1]), (t < 45) ? 1 : 0);
    end
    check("dn_dac_off", int'(dac_off[1]), 0);
    check("dn_ch0_hold", int'(target_vol[0]), 15);
    step(1'b0, 3'b000);

    // Ch2 with period 0 goes straight to DONE and ignores ticks.
    cfg(2, 8, 1'b0, 0);
    step(1'b0, 3'b100);
    check("p0_trig_act", int'(env_active[2]), 0);
    for (int t = 1; t <= 10; t++) begin
      step(1'b1, 3'b100);
      check($sformatf("p0_vol_t%0d", t), int'(target_vol[2]), 8);
    end
    check("p0_act", int'(env_active[2]), 0);
    check("p0_dac_off", int'(dac_off[2]), 0);
    step(1'b0, 3'b000);
    cfg(2, 0, 1'b0, 0);
    step(1'b0, 3'b100);
    check("dac_off_set", int'(dac_off[2]), 1);
    check("dac_off_vol", int'(target_vol[2]), 0);
    step(1'b0, 3'b000);

    // Ch0 period 2 from 4 up; retrigger coincident with a tick.
    cfg(0, 4, 1'b1, 2);
    step(1'b0, 3'b001);
    step(1'b1, 3'b001);
    check("rt_pre_t1", int'(target_vol[0]), 4);
    step(1'b1, 3'b001);
    check("rt_pre_t2", int'(target_vol[0]), 5);
    step(1'b0, 3'b000);
    step(1'b1, 3'b001);
    check("rt_trig_vol", int'(target_vol[0]), 4);
    check("rt_trig_act", int'(env_active[0]), 1);
    step(1'b1, 3'b001);
    check("rt_post_t1", int'(target_vol[0]), 4);
    step(1'b1, 3'b001);
    check("rt_post_t2", int'(target_vol[0]), 5);
    check("rt_post_act", int'(env_active[0]), 1);

    // Asynchronous reset mid-cycle while ch0 runs at volume 5.
    #2 reset = 1'b1;
    #1;
    check("arst_vol0", int'(target_vol[0]), 0);
    check("arst_active", int'(env_active), 0);
    check("arst_dac_off", int'(dac_off), 7);
    @(negedge clk);
    start = '0;
    reset = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      step(1'b1, 3'b000);
      check($sformatf("arst_hold_t%0d", t), int'(target_vol[0]), 0);
    end
    check("arst_hold_act", int'(env_active[0]), 0);

    // Two channels, different settings, start held high across 5 ticked cycles.
    cfg(0, 2, 1'b1, 1);
    cfg(1, 10, 1'b0, 2);
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, 3'b011);
      check($sformatf("dual_ch0_k%0d", k), int'(target_vol[0]), 2 + (k - 1));
      check($sformatf("dual_ch1_k%0d", k), int'(target_vol[1]), 10 - (k - 1) / 2);
    end
    check("dual_active", int'(env_active), 3);
    check("dual_ch2_idle", int'(target_vol[2]), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_gb_envelope_bank
